// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared data bus: one grant at a time, held until the owner drops
// its request, then waits for memory Ready low. Optional grant-hold limit under `ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 4,
  parameter int OWNER_W   = 2,
  parameter int MAX_HOLD  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] Bus_RQ,
  input  logic                 Bus_Mem_Ready,
  output logic [N_MASTERS-1:0] Bus_GRANT,
  output logic [OWNER_W-1:0]   Bus_Owner,
  output logic                 Bus_Busy,
  output logic                 Timeout_Flag
);

  typedef enum logic [1:0] {
    ARB_IDLE         = 2'd0,
    ARB_GRANTED      = 2'd1,
    ARB_WAIT_MEM_LOW = 2'd2
  } arb_state_e;

  arb_state_e             state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic                   busy_q, busy_d;
  logic [N_MASTERS-1:0]   mask_s;
  logic [N_MASTERS-1:0]   elig_s;
  logic [OWNER_W-1:0]     winner_s;
  logic                   win_valid_s;
  logic                   limit_hit_s;
  logic                   revoke_s;

  assign elig_s   = Bus_RQ & ~mask_s;
  assign revoke_s = (state_q == ARB_GRANTED) && Bus_RQ[owner_q] && limit_hit_s;

  // Round-robin search: first eligible index strictly after the pointer, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    winner_s    = '0;
    win_valid_s = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(ptr_q) + k) % N_MASTERS;
      if (!win_valid_s && elig_s[idx]) begin
        winner_s    = OWNER_W'(idx);
        win_valid_s = 1'b1;
      end else begin
        winner_s    = winner_s;
        win_valid_s = win_valid_s;
      end
    end
  end

  // Next-state and registered-output values for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (win_valid_s && !Bus_Mem_Ready) begin
          state_d           = ARB_GRANTED;
          grant_d[winner_s] = 1'b1;
          owner_d           = winner_s;
          ptr_d             = winner_s;
          busy_d            = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANTED: begin
        // Only the owner's bit matters here; other requests never preempt.
        if (!Bus_RQ[owner_q] || revoke_s) begin
          state_d = ARB_WAIT_MEM_LOW;
          grant_d = '0;
        end else begin
          state_d = ARB_GRANTED;
        end
      end
      ARB_WAIT_MEM_LOW: begin
        grant_d = '0;
        if (!Bus_Mem_Ready) begin
          state_d = ARB_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ARB_WAIT_MEM_LOW;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= OWNER_W'(N_MASTERS - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0]          hold_q, hold_d;
  logic [N_MASTERS-1:0] mask_q, mask_d;
  logic                 tflag_q;

  assign limit_hit_s = (hold_q == 16'(MAX_HOLD - 1));
  assign mask_s      = mask_q;

  // Hold counter restarts on each new grant and counts granted cycles.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ARB_IDLE && state_d == ARB_GRANTED) begin
      hold_d = 16'd0;
    end else if (state_q == ARB_GRANTED) begin
      hold_d = hold_q + 16'd1;
    end else begin
      hold_d = hold_q;
    end
  end

  // A revoked core stays ineligible until its request is seen low once.
  always_comb begin
    mask_d = mask_q & Bus_RQ;
    if (revoke_s) begin
      mask_d[owner_q] = 1'b1;
    end else begin
      mask_d = mask_d;
    end
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= 16'd0;
      mask_q  <= '0;
      tflag_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      tflag_q <= revoke_s;
    end
  end

  assign Timeout_Flag = tflag_q;
`else
  logic unused_s;

  assign limit_hit_s  = 1'b0;
  assign mask_s       = '0;
  assign Timeout_Flag = 1'b0;
  assign unused_s     = ^(16'(MAX_HOLD));
`endif

  assign Bus_GRANT = grant_q;
  assign Bus_Owner = owner_q;
  assign Bus_Busy  = busy_q;

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin bus arbiter for the shared data bus. Each core's arbitration submodule raises a request line. The arbiter grants the bus to exactly one core, holds the grant until that core drops its request, and waits for the bus memory's Ready to fall before it arbitrates again. The block sits between the per-core arbitration submodules (`D_Bus_RQ` / `D_Bus_GRANT`) and the shared bus memory.

## Interface
- `N_MASTERS`, default 4: number of requesting cores, 1..16.
- `OWNER_W`, default 2: width of the owner index; must equal ceil(log2(N_MASTERS)), minimum 1.
- `MAX_HOLD`, default 64: grant-hold limit in cycles; used only with `ARB_TIMEOUT_EN`; range 2..65535.

- `clk` input 1: system clock, rising edge. One clock; reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high reset.
- `Bus_RQ` input N_MASTERS: per-core request, bit i from core i's `D_Bus_RQ`.
- `Bus_Mem_Ready` input 1: shared memory Ready (`Bus_DataMem_Ready`).
- `Bus_GRANT` output N_MASTERS: one-hot or zero; bit i drives core i's `D_Bus_GRANT`.
- `Bus_Owner` output OWNER_W: index of the current or last granted core.
- `Bus_Busy` output 1: high in any state other than ARB_IDLE.
- `Timeout_Flag` output 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- All outputs are registered.
- Reset values: `Bus_GRANT` = 0, `Bus_Owner` = 0, `Bus_Busy` = 0, `Timeout_Flag` = 0, state ARB_IDLE.
- Internal reset values: round-robin pointer = N_MASTERS-1, so core 0 wins first; hold counter = 0; revoke mask = 0.
- FSM states:
  - **ARB_IDLE**: `Bus_GRANT` = 0. If eligible requests are nonzero and `Bus_Mem_Ready` == 0, select a winner and go to ARB_GRANTED. Otherwise stay.
  - **ARB_GRANTED**: `Bus_GRANT[owner]` = 1. If `Bus_RQ[owner]` == 0, go to ARB_WAIT_MEM_LOW. Requests from other cores have no effect (no preemption).
  - **ARB_WAIT_MEM_LOW**: `Bus_GRANT` = 0. If `Bus_Mem_Ready` == 0, go to ARB_IDLE. Otherwise stay.
- Eligible requests = `Bus_RQ` & ~revoke mask.
- Winner: the first eligible index after the pointer, searching upward modulo N_MASTERS.
- On a grant:
  - pointer ← winner and `Bus_Owner` ← winner;
  - on the next request the last winner has lowest priority.
- Simultaneous requests: round-robin order only. Simultaneous RQ rise and RQ fall from different cores: the FSM acts only on the owner's bit.
- `Bus_Mem_Ready` stuck high in ARB_IDLE blocks all grants. This is intentional: a stale transaction must drain first.
- N_MASTERS = 1: the pointer is constant. Behaviour is otherwise identical.
- Reset in any state, including mid-grant: next edge forces reset values. No handshake completion is attempted.

## Timing
- Grant latency: request and Ready low sampled at edge t in ARB_IDLE → `Bus_GRANT` high after edge t. That is one cycle after RQ rises, when RQ rises before edge t.
- Release: owner RQ low sampled at edge t → `Bus_GRANT` low after edge t.
- Minimum `Bus_GRANT` low gap between two grants: 2 cycles. This holds when `Bus_Mem_Ready` is already low: one cycle in ARB_WAIT_MEM_LOW, one cycle in ARB_IDLE.
- `Bus_Busy` rises with `Bus_GRANT` and falls on entry to ARB_IDLE.
- `Bus_Owner` changes only on the edge that enters ARB_GRANTED. It holds its value in all other states.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined:**
  - A hold counter (16 bits) clears on entry to ARB_GRANTED and increments each cycle in ARB_GRANTED.
  - When the counter reaches MAX_HOLD-1 while owner RQ is still high, the next edge does the following:
    - `Bus_GRANT` ← 0 and state ← ARB_WAIT_MEM_LOW;
    - `Timeout_Flag` = 1 for one cycle;
    - revoke mask bit [owner] ← 1.
  - A revoke mask bit clears on the first cycle its `Bus_RQ` bit is sampled low.
  - If the owner drops RQ on the same cycle the limit is reached, treat it as a normal release: no flag, no mask.
- **Undefined:**
  - No counter and no mask logic; the revoke mask is constant 0.
  - `Timeout_Flag` is tied to 0.
  - A grant is held indefinitely.

## Test plan
- Reset, then `Bus_RQ` = 4'b0001 with `Bus_Mem_Ready` = 0 → `Bus_GRANT` = 4'b0001 and `Bus_Owner` = 0, one cycle after RQ is sampled. RQ drops → `Bus_GRANT` = 0 next cycle; `Bus_Busy` falls 1 cycle later.
- `Bus_RQ` = 4'b1111 held, each owner drops and re-raises RQ after 3 granted cycles → grant order 0, 1, 2, 3, 0 with a 2-cycle low gap between grants.
- Owner drops RQ while `Bus_Mem_Ready` = 1 for 5 cycles, with core 2 requesting → no grant until 1 cycle after Ready falls; then `Bus_GRANT` = 4'b0100.
- `ARB_TIMEOUT_EN`, MAX_HOLD = 8, core 1 holds RQ → grant lasts exactly 8 cycles, `Timeout_Flag` pulses once, and core 3's request is granted next. Core 1 is not re-granted until its RQ has been low for at least one cycle.
- `reset` asserted for one cycle while `Bus_GRANT` = 4'b0010 → all outputs 0 after that edge. Core 0 requests afterwards → granted first.
